// File: rtl/lfsr_gen.sv
// lfsr_gen: maximal-length XNOR Fibonacci LFSR with seed load, single step, STRIDE-step draw and wrap detect.
// Optional feature macro LFSR_LOCKUP_FIX_EN: an all-ones seed is stored as all-zeros and lockup_o is tied low.
module lfsr_gen #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = '0,
  parameter logic [WIDTH-1:0] RESET_SEED = '0,
  parameter int unsigned      STRIDE     = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  input  logic             draw_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lfsr_data_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..16");
  end
  if (STRIDE < 1 || STRIDE > 255) begin : g_bad_stride
    $error("lfsr_gen: STRIDE must be in 1..255");
  end
  if (RESET_SEED == '1) begin : g_bad_seed
    $error("lfsr_gen: RESET_SEED must not be all-ones");
  end

  // Maximal-length XNOR tap masks, one per supported width.
  function automatic logic [15:0] builtinTaps(input int unsigned w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      BUILTIN    = builtinTaps(WIDTH);
  localparam logic [WIDTH-1:0] TAP_MASK   = (TAPS != '0) ? TAPS : BUILTIN[WIDTH-1:0];
  localparam logic [7:0]       STRIDE_CNT = 8'(STRIDE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             feedback;
  logic [WIDTH-1:0] nextLfsr;
  logic [WIDTH-1:0] seedFixed;
  logic             advance;

  assign feedback = ~^(lfsr_q & TAP_MASK);
  assign nextLfsr = {lfsr_q[WIDTH-2:0], feedback};

`ifdef LFSR_LOCKUP_FIX_EN
  assign seedFixed = (seed_i == '1) ? '0 : seed_i;
  assign lockup_o  = 1'b0;
`else
  assign seedFixed = seed_i;
  assign lockup_o  = (lfsr_q == '1);
`endif

  // Priority per edge: load, then draw accept, then a RUN step, then a single IDLE step.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    advance = 1'b0;
    if (load_i) begin
      state_d = IDLE;
      lfsr_d  = seedFixed;
      start_d = seedFixed;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (draw_i) begin
            state_d = RUN;
            cnt_d   = STRIDE_CNT;
          end else if (step_i) begin
            advance = 1'b1;
          end
        end
        RUN: begin
          advance = 1'b1;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (advance) begin
      lfsr_d = nextLfsr;
      wrap_d = (nextLfsr == start_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lfsr_q  <= RESET_SEED;
      start_q <= RESET_SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;
  assign lfsr_data_o = lfsr_q;

`ifndef SYNTHESIS
  // A draw in flight always has steps left, and completion is never reported while still running.
  assert property (@(posedge clk_i) disable iff (!rst_ni) busy_o |-> (cnt_q != 8'd0));
  assert property (@(posedge clk_i) disable iff (!rst_ni) done_o |-> !busy_o);
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen at WIDTH 3 (sequence, draw, abort, async reset), 8 (period) and 4 (lockup).
// Expectations honour LFSR_LOCKUP_FIX_EN when the bench and design are built with it.
module tb_lfsr_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic       load3, step3, draw3;
  logic [2:0] seed3;
  logic       busy3, done3, wrap3, lockup3;
  logic [2:0] data3;

  logic       load8, step8, draw8;
  logic [7:0] seed8;
  logic       busy8, done8, wrap8, lockup8;
  logic [7:0] data8;

  logic       load4, step4, draw4;
  logic [3:0] seed4;
  logic       busy4, done4, wrap4, lockup4;
  logic [3:0] data4;

  int checkCount = 0;
  int errorCount = 0;

  lfsr_gen #(.WIDTH(3), .STRIDE(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load3), .seed_i(seed3), .step_i(step3), .draw_i(draw3),
    .busy_o(busy3), .done_o(done3), .lfsr_data_o(data3), .wrap_o(wrap3), .lockup_o(lockup3)
  );

  lfsr_gen #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load8), .seed_i(seed8), .step_i(step8), .draw_i(draw8),
    .busy_o(busy8), .done_o(done8), .lfsr_data_o(data8), .wrap_o(wrap8), .lockup_o(lockup8)
  );

  lfsr_gen #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load4), .seed_i(seed4), .step_i(step4), .draw_i(draw4),
    .busy_o(busy4), .done_o(done4), .lfsr_data_o(data4), .wrap_o(wrap4), .lockup_o(lockup4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [2:0] sd, input logic st, input logic dr);
    load3 = ld;
    seed3 = sd;
    step3 = st;
    draw3 = dr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed WIDTH=3 sequence from 0 with taps 0x6.
  logic [2:0] seq3 [7];
  logic [3:0] lockExp;
  logic [3:0] lockStepExp;
  logic       lockWrapExp;
  int         firstZero;
  int         wrapSeen;
  int         lockSeen;

  initial begin
    seq3 = '{3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4, 3'd0};
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    load8 = 1'b0; seed8 = 8'h00; step8 = 1'b0; draw8 = 1'b0;
    load4 = 1'b0; seed4 = 4'h0;  step4 = 1'b0; draw4 = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_data3",   32'(data3),   32'd0);
    checkOutput("rst_busy3",   32'(busy3),   32'd0);
    checkOutput("rst_done3",   32'(done3),   32'd0);
    checkOutput("rst_wrap3",   32'(wrap3),   32'd0);
    checkOutput("rst_lockup3", 32'(lockup3), 32'd0);
    checkOutput("rst_data8",   32'(data8),   32'd0);
    checkOutput("rst_busy8",   32'(busy8),   32'd0);
    checkOutput("rst_done8",   32'(done8),   32'd0);
    checkOutput("rst_busy4",   32'(busy4),   32'd0);
    checkOutput("rst_done4",   32'(done4),   32'd0);
    rst_n = 1'b1;

    // Free-running single steps through the full WIDTH=3 period.
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      checkOutput("seq_data", 32'(data3), 32'(seq3[i]));
      checkOutput("seq_wrap", 32'(wrap3), (i == 6) ? 32'd1 : 32'd0);
    end

    // Seed 0, then one draw; step stays high while busy and must be ignored.
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("load0_data", 32'(data3), 32'd0);
    checkOutput("load0_wrap", 32'(wrap3), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("draw_busy",   32'(busy3), 32'd1);
      checkOutput("draw_nodone", 32'(done3), 32'd0);
      nextCycle();
    end
    checkOutput("draw_done", 32'(done3), 32'd1);
    checkOutput("draw_idle", 32'(busy3), 32'd0);
    checkOutput("draw_word", 32'(data3), 32'd6);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("draw_pulse", 32'(done3), 32'd0);
    checkOutput("draw_hold",  32'(data3), 32'd6);

    // Abort a draw after two steps (6->5->2) with a load of 5.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("abort_mid", 32'(data3), 32'd2);
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("abort_data", 32'(data3), 32'd5);
    checkOutput("abort_busy", 32'(busy3), 32'd0);
    checkOutput("abort_done", 32'(done3), 32'd0);
    nextCycle();
    checkOutput("abort_nodone", 32'(done3), 32'd0);
    checkOutput("abort_hold",   32'(data3), 32'd5);

    // Draw from 5: 5->2->4->0, then a back-to-back draw accepted on the done cycle: 0->1->3->6.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    repeat (3) nextCycle();
    checkOutput("draw5_done", 32'(done3), 32'd1);
    checkOutput("draw5_word", 32'(data3), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("b2b_busy", 32'(busy3), 32'd1);
    checkOutput("b2b_done", 32'(done3), 32'd0);
    repeat (3) nextCycle();
    checkOutput("b2b_fin",  32'(done3), 32'd1);
    checkOutput("b2b_word", 32'(data3), 32'd6);

    // load, step and draw together in IDLE: only the load happens.
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("all_data", 32'(data3), 32'd3);
    checkOutput("all_busy", 32'(busy3), 32'd0);

    // WIDTH=8 full period from 0 with bounded stepping.
    load8 = 1'b1; seed8 = 8'h00;
    nextCycle();
    load8 = 1'b0; step8 = 1'b1;
    firstZero = 0; wrapSeen = 0; lockSeen = 0;
    for (int i = 1; i <= 300; i++) begin
      nextCycle();
      if (wrap8) wrapSeen++;
      if (lockup8) lockSeen++;
      if (data8 == 8'h00) begin
        firstZero = i;
        break;
      end
    end
    step8 = 1'b0;
    checkOutput("period_len",    32'(firstZero), 32'd255);
    checkOutput("period_wraps",  32'(wrapSeen),  32'd1);
    checkOutput("period_lockup", 32'(lockSeen),  32'd0);

    // WIDTH=4 all-ones seed.
`ifdef LFSR_LOCKUP_FIX_EN
    lockExp = 4'h0; lockStepExp = 4'h1; lockWrapExp = 1'b0;
`else
    lockExp = 4'hF; lockStepExp = 4'hF; lockWrapExp = 1'b1;
`endif
    load4 = 1'b1; seed4 = 4'hF;
    nextCycle();
    load4 = 1'b0;
    checkOutput("lock_data",   32'(data4),   32'(lockExp));
    checkOutput("lock_flag",   32'(lockup4), (lockExp == 4'hF) ? 32'd1 : 32'd0);
    step4 = 1'b1;
    nextCycle();
    step4 = 1'b0;
    checkOutput("lock_step",   32'(data4),   32'(lockStepExp));
    checkOutput("lock_wrap",   32'(wrap4),   32'(lockWrapExp));
    checkOutput("lock_flag2",  32'(lockup4), (lockStepExp == 4'hF) ? 32'd1 : 32'd0);

    // Asynchronous reset mid-draw (3->6 after one step), checked before the next rising edge.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("pre_rst_data", 32'(data3), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_data", 32'(data3), 32'd0);
    checkOutput("arst_busy", 32'(busy3), 32'd0);
    checkOutput("arst_data4", 32'(data4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("arst_idle", 32'(busy3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
